btn_event_arbiter: RTL and testbench
====================================

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk_in cycles per sample_tick period; legal range 2..2^20, counter width 20 bits.
REQ-002 clk_in  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pulse_in  input  4  one-clock event pulses from four debouncer/one-shot channels, bit i = channel i.
REQ-005 sample_tick  output  1  one-cycle sample enable for the upstream debouncers.
REQ-006 evt_valid  output  1  event offered to the consumer.
REQ-007 evt_id  output  2  channel number of the offered event.
REQ-008 evt_ready  input  1  consumer accepts the event.
REQ-009 overrun  output  4  sticky per-channel flag: event lost.
REQ-010 clr_overrun  input  1  clears all overrun bits.
REQ-011 busy  output  1  high while any event is pending or offered.

Function
REQ-012 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; sample_tick SHALL be high exactly in cycles where the counter equals TICK_DIV-1.
REQ-013 The counter SHALL free-run, independent of arbiter state.
REQ-014 pend[i] SHALL be set at the clock edge that samples pulse_in[i]=1.
REQ-015 pend[i] SHALL be cleared at the edge that completes a handshake (evt_valid=1, evt_ready=1) for evt_id=i.
REQ-016 Pulse on channel i in the handshake-completion cycle for i: pend[i] SHALL remain set (new event); overrun[i] SHALL NOT be set.
REQ-017 Pulse on channel i while pend[i]=1 and not being cleared that cycle: overrun[i] SHALL be set; pend[i] stays 1; the event is merged.
REQ-018 overrun bits SHALL clear on clr_overrun=1; a same-cycle set condition SHALL win over clr_overrun for that bit.
REQ-019 FSM states: IDLE, OFFER.
REQ-020 IDLE: evt_valid=0; if pend!=0, at next edge go to OFFER, load evt_id with the round-robin winner, and drive evt_valid=1.
REQ-021 OFFER: evt_valid=1; evt_id SHALL stay stable; on evt_ready=1, complete the handshake, store last_grant=evt_id, and return to IDLE.
REQ-022 OFFER without evt_ready: remain in OFFER indefinitely.
REQ-023 evt_valid SHALL therefore be low for at least one cycle between consecutive events.
REQ-024 Round-robin: scan order starts at (last_grant+1) mod 4 and ascends with wrap; the first set pend bit wins.
REQ-025 Latency: pulse_in high in cycle t SHALL give evt_valid high in cycle t+2 when the FSM is in IDLE and no other channel is pending.
REQ-026 evt_ready while in IDLE SHALL be ignored.
REQ-027 busy SHALL equal (pend!=0) OR (state==OFFER), registered-state based, with no combinational path from inputs.

Reset
REQ-028 While reset=1, outputs SHALL be held at: state=IDLE, pend=0, overrun=0, tick counter=0, sample_tick=0, evt_valid=0, evt_id=0, last_grant=3 (channel 0 first), busy=0.
REQ-029 Reset asserted in OFFER SHALL abort the offer; the pending event is discarded.
REQ-030 After reset deasserts, the first sample_tick SHALL occur TICK_DIV cycles later.

Verification
REQ-031 TICK_DIV=4, reset released: sample_tick high in cycles 3, 7, 11, each for exactly 1 cycle.
REQ-032 Single pulse ch2 at cycle t, evt_ready=1 held: evt_valid=1 and evt_id=2 in cycle t+2 only; busy low from t+3.
REQ-033 Pulses on ch0..ch3 in the same cycle, evt_ready=1: events granted in order 0,1,2,3 with evt_valid low 1 cycle between each; then a ch0+ch1 pair is served as 0,1.
REQ-034 ch1 offered with evt_ready=0, second ch1 pulse arrives: overrun=4'b0010 and one event is delivered; clr_overrun in the same cycle as a third ch1 pulse leaves overrun[1]=1.
REQ-035 Pulse ch3 in the handshake-completion cycle for ch3: no overrun; ch3 is offered again 2 cycles later.
REQ-036 Reset pulsed in OFFER: evt_valid=0 and busy=0 immediately; no event follows after release.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// Collects one-clock event pulses from four channels and offers them one at a
// time to a valid/ready consumer in round-robin order; also generates the sample tick.
module btn_event_arbiter #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] pulse_in,
  output logic       sample_tick,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  input  logic       evt_ready,
  output logic [3:0] overrun,
  input  logic       clr_overrun,
  output logic       busy
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [19:0] CNT_MAX = 20'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  overrun_q, overrun_d;
  logic [1:0]  evt_id_q, evt_id_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  clr_mask;
  logic [3:0]  ovr_set;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;

  // Free-running tick counter, independent of the arbiter.
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 20'd1;
  end

  // Round-robin pick: scan from last_grant+1 upward with wrap.
  always_comb begin
    win   = last_q + 2'd1;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && pend_q[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    last_d   = last_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d  = OFFER;
          evt_id_d = win;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          clr_mask[evt_id_q] = 1'b1;
          last_d             = evt_id_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pulse in the clearing cycle re-arms the channel instead of counting as lost.
    pend_d    = (pend_q & ~clr_mask) | pulse_in;
    ovr_set   = pulse_in & pend_q & ~clr_mask;
    overrun_d = ovr_set | (clr_overrun ? '0 : overrun_q);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      overrun_q <= '0;
      evt_id_q  <= '0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      evt_id_q  <= evt_id_d;
      last_q    <= last_d;
    end
  end

  assign sample_tick = (cnt_q == CNT_MAX);
  assign evt_valid   = (state_q == OFFER);
  assign evt_id      = evt_id_q;
  assign overrun     = overrun_q;
  assign busy        = (pend_q != '0) || (state_q == OFFER);

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter with TICK_DIV=4.
module tb_btn_event_arbiter;

  logic       clk_in = 1'b0;
  logic       reset;
  logic [3:0] pulse_in;
  logic       sample_tick;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] overrun;
  logic       clr_overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  btn_event_arbiter #(.TICK_DIV(4)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .sample_tick (sample_tick),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    pulse_in    = '0;
    evt_ready   = 1'b0;
    clr_overrun = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expects an offer of id in the current cycle when v is set, otherwise no offer.
  task automatic chk_offer(input string tag, input logic v, input logic [1:0] id);
    chk_eq({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) chk_eq({tag, "_id"}, 32'(evt_id), 32'(id));
  endtask

  initial begin
    reset       = 1'b1;
    pulse_in    = '0;
    evt_ready   = 1'b0;
    clr_overrun = 1'b0;
    step();
    step();
    chk_eq("rst_valid",   32'(evt_valid),   32'd0);
    chk_eq("rst_id",      32'(evt_id),      32'd0);
    chk_eq("rst_busy",    32'(busy),        32'd0);
    chk_eq("rst_overrun", 32'(overrun),     32'd0);
    chk_eq("rst_tick",    32'(sample_tick), 32'd0);

    // Tick: high in cycles 3, 7, 11 after release.
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      chk_eq($sformatf("tick_c%0d", c), 32'(sample_tick), 32'((c % 4) == 3));
      step();
    end

    // Single ch2 pulse with ready held.
    do_reset();
    evt_ready = 1'b1;
    pulse_in  = 4'b0100;
    step();
    pulse_in = '0;
    chk_offer("s2_t1", 1'b0, 2'd0);
    step();
    chk_offer("s2_t2", 1'b1, 2'd2);
    step();
    chk_offer("s2_t3", 1'b0, 2'd0);
    chk_eq("s2_busy_t3", 32'(busy), 32'd0);

    // All four at once, then ch0+ch1.
    do_reset();
    evt_ready = 1'b1;
    pulse_in  = 4'b1111;
    step();
    pulse_in = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_offer($sformatf("all_g%0d", k), 1'b1, 2'(k));
      step();
      chk_offer($sformatf("all_gap%0d", k), 1'b0, 2'd0);
    end
    chk_eq("all_busy_end", 32'(busy), 32'd0);
    pulse_in = 4'b0011;
    step();
    pulse_in = '0;
    step();
    chk_offer("pair_g0", 1'b1, 2'd0);
    step();
    chk_offer("pair_gap", 1'b0, 2'd0);
    step();
    chk_offer("pair_g1", 1'b1, 2'd1);
    step();
    chk_offer("pair_end", 1'b0, 2'd0);
    chk_eq("pair_busy", 32'(busy), 32'd0);

    // Overrun on ch1 and clear-vs-set priority.
    do_reset();
    pulse_in = 4'b0010;
    step();
    pulse_in = '0;
    step();
    chk_offer("ov_offer", 1'b1, 2'd1);
    pulse_in = 4'b0010;
    step();
    pulse_in = '0;
    chk_eq("ov_set", 32'(overrun), 32'h2);
    chk_offer("ov_hold", 1'b1, 2'd1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk_offer("ov_after", 1'b0, 2'd0);
    chk_eq("ov_busy", 32'(busy), 32'd0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk_offer("ov_one_evt", 1'b0, 2'd0);
    chk_eq("ov_clr", 32'(overrun), 32'h0);
    pulse_in = 4'b0010;
    step();
    clr_overrun = 1'b1;
    step();
    pulse_in    = '0;
    clr_overrun = 1'b0;
    chk_eq("ov_set_wins", 32'(overrun), 32'h2);
    chk_offer("ov_drain", 1'b1, 2'd1);
    evt_ready = 1'b1;
    step();
    chk_offer("ov_drain_end", 1'b0, 2'd0);

    // Re-pulse ch3 in its own completion cycle.
    do_reset();
    evt_ready = 1'b1;
    pulse_in  = 4'b1000;
    step();
    pulse_in = '0;
    step();
    chk_offer("rp_first", 1'b1, 2'd3);
    pulse_in = 4'b1000;
    step();
    pulse_in = '0;
    chk_offer("rp_gap", 1'b0, 2'd0);
    chk_eq("rp_no_ovr", 32'(overrun), 32'h0);
    chk_eq("rp_busy_gap", 32'(busy), 32'd1);
    step();
    chk_offer("rp_second", 1'b1, 2'd3);
    step();
    chk_eq("rp_busy_end", 32'(busy), 32'd0);

    // Reset during an offer.
    do_reset();
    pulse_in = 4'b0001;
    step();
    pulse_in = '0;
    step();
    chk_offer("ar_offer", 1'b1, 2'd0);
    reset = 1'b1;
    #1;
    chk_eq("ar_valid", 32'(evt_valid), 32'd0);
    chk_eq("ar_busy",  32'(busy),      32'd0);
    step();
    reset     = 1'b0;
    evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_eq($sformatf("ar_quiet%0d", c), 32'({evt_valid, busy}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
